// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-write-port register file with a per-register busy scoreboard.
// Define REG_FILE_SB_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_sb #(
  parameter int NUM_RS    = 2,
  parameter int NUM_WS    = 2,
  parameter int NUM_LK    = 1,
  parameter int ZERO_REG  = 1,
  parameter int NUM_REG   = 32,
  parameter int REG_WIDTH = 32
) (
  input  logic                                     clk_i,
  input  logic                                     arst_ni,
  input  logic [NUM_WS-1:0][$clog2(NUM_REG)-1:0]   rd_addr_i,
  input  logic [NUM_WS-1:0][REG_WIDTH-1:0]         rd_data_i,
  input  logic [NUM_WS-1:0]                        rd_en_i,
  input  logic [NUM_LK-1:0][$clog2(NUM_REG)-1:0]   lk_addr_i,
  input  logic [NUM_LK-1:0]                        lk_en_i,
  input  logic [NUM_RS-1:0][$clog2(NUM_REG)-1:0]   rs_addr_i,
  output logic [NUM_RS-1:0][REG_WIDTH-1:0]         rs_data_o,
  output logic [NUM_RS-1:0]                        rs_busy_o,
  output logic [NUM_REG-1:0]                       busy_o
);

  localparam int AW = $clog2(NUM_REG);

  logic [NUM_REG-1:0][REG_WIDTH-1:0] mem_r;
  logic [NUM_REG-1:0][REG_WIDTH-1:0] mem_nxt_s;
  logic [NUM_REG-1:0]                busy_r;
  logic [NUM_REG-1:0]                busy_nxt_s;
  logic [NUM_REG-1:0]                set_s;
  logic [NUM_REG-1:0]                clr_s;

  // Next-state: later write ports override earlier ones; a lock beats a release.
  always_comb begin
    mem_nxt_s  = mem_r;
    busy_nxt_s = busy_r;
    set_s      = '0;
    clr_s      = '0;
    for (int r = 0; r < NUM_REG; r++) begin
      for (int w = 0; w < NUM_WS; w++) begin
        mem_nxt_s[r] = (rd_en_i[w] && (rd_addr_i[w] == AW'(r))) ? rd_data_i[w] : mem_nxt_s[r];
        clr_s[r]     = clr_s[r] | (rd_en_i[w] && (rd_addr_i[w] == AW'(r)));
      end
      for (int l = 0; l < NUM_LK; l++) begin
        set_s[r] = set_s[r] | (lk_en_i[l] && (lk_addr_i[l] == AW'(r)));
      end
      busy_nxt_s[r] = set_s[r] | (busy_r[r] & ~clr_s[r]);
    end
    mem_nxt_s[0]  = (ZERO_REG != 0) ? {REG_WIDTH{1'b0}} : mem_nxt_s[0];
    busy_nxt_s[0] = (ZERO_REG != 0) ? 1'b0 : busy_nxt_s[0];
  end

  // Architectural state and scoreboard.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      mem_r  <= '0;
      busy_r <= '0;
    end else begin
      mem_r  <= mem_nxt_s;
      busy_r <= busy_nxt_s;
    end
  end

  // Read ports; outputs are forced low while reset is held.
  always_comb begin
    rs_data_o = '0;
    rs_busy_o = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      rs_data_o[i] = mem_r[rs_addr_i[i]];
      rs_busy_o[i] = busy_r[rs_addr_i[i]];
`ifdef REG_FILE_SB_BYPASS_EN
      for (int w = 0; w < NUM_WS; w++) begin
        rs_data_o[i] = (rd_en_i[w] && (rd_addr_i[w] == rs_addr_i[i])) ? rd_data_i[w] : rs_data_o[i];
        rs_busy_o[i] = (rd_en_i[w] && (rd_addr_i[w] == rs_addr_i[i])) ? set_s[rs_addr_i[i]] : rs_busy_o[i];
      end
`endif
      rs_data_o[i] = (!arst_ni || ((ZERO_REG != 0) && (rs_addr_i[i] == {AW{1'b0}})))
                     ? {REG_WIDTH{1'b0}} : rs_data_o[i];
      rs_busy_o[i] = (!arst_ni || ((ZERO_REG != 0) && (rs_addr_i[i] == {AW{1'b0}})))
                     ? 1'b0 : rs_busy_o[i];
    end
  end

  assign busy_o = busy_r;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: driver pushes model expectations, monitor checks them.
module tb_reg_file_sb;

  localparam int NRS = 2;
  localparam int NWS = 2;
  localparam int NLK = 1;
  localparam int ZR  = 1;
  localparam int NREG = 32;
  localparam int RW  = 32;
  localparam int AW  = 5;

  logic                     clk = 1'b0;
  logic                     arst_ni;
  logic [NWS-1:0][AW-1:0]   rd_addr;
  logic [NWS-1:0][RW-1:0]   rd_data;
  logic [NWS-1:0]           rd_en;
  logic [NLK-1:0][AW-1:0]   lk_addr;
  logic [NLK-1:0]           lk_en;
  logic [NRS-1:0][AW-1:0]   rs_addr;
  logic [NRS-1:0][RW-1:0]   rs_data;
  logic [NRS-1:0]           rs_busy;
  logic [NREG-1:0]          busy;

  always #5 clk = ~clk;

  reg_file_sb #(.NUM_RS(NRS), .NUM_WS(NWS), .NUM_LK(NLK), .ZERO_REG(ZR),
                .NUM_REG(NREG), .REG_WIDTH(RW)) dut (
    .clk_i(clk), .arst_ni(arst_ni),
    .rd_addr_i(rd_addr), .rd_data_i(rd_data), .rd_en_i(rd_en),
    .lk_addr_i(lk_addr), .lk_en_i(lk_en),
    .rs_addr_i(rs_addr), .rs_data_o(rs_data), .rs_busy_o(rs_busy),
    .busy_o(busy)
  );

  typedef struct {
    int              port;
    logic [AW-1:0]   addr;
    logic [RW-1:0]   data;
    logic            rbusy;
    logic [NREG-1:0] vec;
  } exp_t;

  exp_t            exp_q[$];
  logic [RW-1:0]   m_mem[NREG];
  logic [NREG-1:0] m_busy;
  int              errors = 0;
  int              checks = 0;

  // Reference model: what each read port must show right now.
  function automatic void push_expect();
    exp_t e;
    logic hit;
    for (int p = 0; p < NRS; p++) begin
      e.port  = p;
      e.addr  = rs_addr[p];
      e.data  = m_mem[e.addr];
      e.rbusy = m_busy[e.addr];
`ifdef REG_FILE_SB_BYPASS_EN
      hit = 1'b0;
      for (int w = 0; w < NWS; w++)
        if (rd_en[w] && rd_addr[w] == e.addr) begin
          e.data = rd_data[w];
          e.rbusy = 1'b0;
          hit = 1'b1;
        end
      if (hit)
        for (int l = 0; l < NLK; l++)
          if (lk_en[l] && lk_addr[l] == e.addr) e.rbusy = 1'b1;
`else
      hit = 1'b0;
`endif
      if (!arst_ni || (ZR != 0 && e.addr == 0)) begin
        e.data = '0;
        e.rbusy = 1'b0;
      end
      e.vec = arst_ni ? m_busy : '0;
      exp_q.push_back(e);
    end
  endfunction

  // Reference model: effect of the clock edge just taken.
  function automatic void model_update();
    if (!arst_ni) begin
      for (int r = 0; r < NREG; r++) m_mem[r] = '0;
      m_busy = '0;
    end else begin
      for (int w = 0; w < NWS; w++)
        if (rd_en[w]) begin
          m_mem[rd_addr[w]] = rd_data[w];
          m_busy[rd_addr[w]] = 1'b0;
        end
      for (int l = 0; l < NLK; l++)
        if (lk_en[l]) m_busy[lk_addr[l]] = 1'b1;
      if (ZR != 0) begin
        m_mem[0] = '0;
        m_busy[0] = 1'b0;
      end
    end
  endfunction

  task automatic cycle();
    push_expect();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rd_en = '0;
    lk_en = '0;
    rd_addr = '0;
    rd_data = '0;
    lk_addr = '0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREG - 1)) : AW'($urandom_range(0, 7));
  endfunction

  task automatic rand_inputs();
    for (int w = 0; w < NWS; w++) begin
      rd_en[w] = 1'($urandom_range(0, 1));
      rd_addr[w] = rnd_addr();
      rd_data[w] = $urandom;
    end
    for (int l = 0; l < NLK; l++) begin
      lk_en[l] = ($urandom_range(0, 2) == 0);
      lk_addr[l] = rnd_addr();
    end
    for (int p = 0; p < NRS; p++) rs_addr[p] = rnd_addr();
  endtask

  // Monitor: compare every pending expectation away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rs_data[e.port] !== e.data) begin
          errors++;
          $display("FAIL data p%0d a%0d: got %h want %h", e.port, e.addr, rs_data[e.port], e.data);
        end
        checks++;
        if (rs_busy[e.port] !== e.rbusy) begin
          errors++;
          $display("FAIL rs_busy p%0d a%0d: got %b want %b", e.port, e.addr, rs_busy[e.port], e.rbusy);
        end
        checks++;
        if (busy !== e.vec) begin
          errors++;
          $display("FAIL busy_o: got %h want %h", busy, e.vec);
        end
      end
    end
  end

  initial begin
    arst_ni = 1'b0;
    idle();
    rs_addr = '0;
    for (int r = 0; r < NREG; r++) m_mem[r] = '0;
    m_busy = '0;
    @(posedge clk);
    #1;
    // reset held for 100 ns with outputs checked low
    repeat (10) begin
      rs_addr[0] = rnd_addr();
      rs_addr[1] = rnd_addr();
      cycle();
    end
    arst_ni = 1'b1;
    for (int a = 0; a < NREG / 2; a++) begin
      rs_addr[0] = AW'(2 * a);
      rs_addr[1] = AW'(2 * a + 1);
      cycle();
    end
    // write collision on reg 5
    rd_en = 2'b11;
    rd_addr[0] = 5'd5; rd_data[0] = 32'hAAAA_0000;
    rd_addr[1] = 5'd5; rd_data[1] = 32'h5555_1111;
    rs_addr[0] = 5'd5; rs_addr[1] = 5'd5;
    cycle();
    idle();
    cycle();
    // zero register write and lock
    rd_en[0] = 1'b1; rd_addr[0] = 5'd0; rd_data[0] = 32'hDEAD_BEEF;
    lk_en[0] = 1'b1; lk_addr[0] = 5'd0;
    rs_addr[0] = 5'd0; rs_addr[1] = 5'd0;
    cycle();
    idle();
    cycle();
    // scoreboard sequence on reg 7
    rs_addr[0] = 5'd7; rs_addr[1] = 5'd7;
    lk_en[0] = 1'b1; lk_addr[0] = 5'd7;
    cycle();
    idle();
    cycle();
    rd_en[1] = 1'b1; rd_addr[1] = 5'd7; rd_data[1] = 32'h0000_1234;
    cycle();
    idle();
    cycle();
    rd_en[0] = 1'b1; rd_addr[0] = 5'd7; rd_data[0] = 32'h0000_5678;
    lk_en[0] = 1'b1; lk_addr[0] = 5'd7;
    cycle();
    idle();
    cycle();
    // same-cycle write and read of reg 3
    rd_en[0] = 1'b1; rd_addr[0] = 5'd3; rd_data[0] = 32'h0000_CAFE;
    rs_addr[0] = 5'd3; rs_addr[1] = 5'd3;
    cycle();
    idle();
    cycle();
    // random regression with a mid-run reset pulse
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) arst_ni = 1'b0;
      if (i == 503) arst_ni = 1'b1;
      rand_inputs();
      cycle();
    end
    idle();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
